enigma_keyboard: RTL

Front-end stage that sits directly upstream of the enigma core. It turns a raw, bouncy 26-key one-hot keyboard into the core's 5-bit letter input and maintains the three rotor positions the core consumes. It debounces presses, rejects multi-key chords, advances the rotors odometer-style once per accepted key press, and drives the idle code 5'b11111 whenever no key is held.

---
 rtl/enigma_keyboard_if.sv | 27 ++
 rtl/enigma_keyboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/enigma_keyboard_if.sv
// Keyboard-side bundle of enigma_keyboard: raw keys and rotor load request in,
// core letter, rotor positions and press strobe out.
interface enigma_keyboard_if;
    // key_strobe is a one-cycle valid that marks a new letter on bits; there is
    // no ready, the core must take it that cycle. bits stays stable while held.
    logic [25:0] keys;
    logic        load;
    logic [4:0]  init_l;
    logic [4:0]  init_m;
    logic [4:0]  init_r;
    logic [4:0]  bits;
    logic [4:0]  rotor_l;
    logic [4:0]  rotor_m;
    logic [4:0]  rotor_r;
    logic        key_strobe;
    logic [1:0]  dbg_state;

    modport slave (
        input  keys, load, init_l, init_m, init_r,
        output bits, rotor_l, rotor_m, rotor_r, key_strobe, dbg_state
    );

    modport master (
        output keys, load, init_l, init_m, init_r,
        input  bits, rotor_l, rotor_m, rotor_r, key_strobe, dbg_state
    );
endinterface

// File: rtl/enigma_keyboard.sv
// Enigma front end: debounces a one-hot keyboard, rejects chords, and steps the
// three rotors odometer-style once per accepted press.
module enigma_keyboard #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NOTCH_R         = 16,
    parameter int unsigned NOTCH_M         = 4
) (
    input  logic             clk,
    input  logic             restart,
    enigma_keyboard_if.slave kb
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic       DEB_ONE   = (DEBOUNCE_CYCLES == 1);
    localparam logic [4:0] NR        = 5'(NOTCH_R);
    localparam logic [4:0] NM        = 5'(NOTCH_M);
    localparam logic [4:0] IDLE_CODE = 5'h1f;
    localparam logic [4:0] LAST_POS  = 5'd25;

    function automatic logic is_onehot(input logic [25:0] v);
        return (v != 26'd0) && ((v & (v - 26'd1)) == 26'd0);
    endfunction

    function automatic logic [4:0] onehot_index(input logic [25:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] wrap_inc(input logic [4:0] v);
        return (v >= LAST_POS) ? 5'd0 : v + 5'd1;
    endfunction

    logic [25:0] r_sync1;
    logic [25:0] r_sync2;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [25:0] r_cap;
    logic [4:0]  r_idx;
    logic [4:0]  r_bits;
    logic        r_strobe;
    logic [4:0]  r_rot_l;
    logic [4:0]  r_rot_m;
    logic [4:0]  r_rot_r;

    state_t      w_state_nx;
    logic [7:0]  w_cnt_nx;
    logic [25:0] w_cap_nx;
    logic [4:0]  w_idx_nx;
    logic [4:0]  w_bits_nx;
    logic        w_accept;
    logic        w_sv_onehot;
    logic        w_sv_zero;
    logic [4:0]  w_sv_idx;
    logic        w_load_ok;
    logic [4:0]  w_base_l;
    logic [4:0]  w_base_m;
    logic [4:0]  w_base_r;
    logic        w_carry_m;
    logic        w_carry_l;
    logic [4:0]  w_rot_l_nx;
    logic [4:0]  w_rot_m_nx;
    logic [4:0]  w_rot_r_nx;

    assign w_sv_onehot = is_onehot(r_sync2);
    assign w_sv_zero   = (r_sync2 == 26'd0);
    assign w_sv_idx    = onehot_index(r_sync2);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cap_nx   = r_cap;
        w_idx_nx   = r_idx;
        w_bits_nx  = r_bits;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                w_bits_nx = IDLE_CODE;
                if (w_sv_onehot) begin
                    w_cap_nx = r_sync2;
                    w_idx_nx = w_sv_idx;
                    w_cnt_nx = 8'd1;
                    if (DEB_ONE) begin
                        w_accept   = 1'b1;
                        w_state_nx = HELD;
                    end else begin
                        w_state_nx = DEB_PRESS;
                    end
                end
            end
            DEB_PRESS: begin
                // Only the exact captured key keeps the count alive; zero,
                // chords and a different key all restart from IDLE.
                if (r_sync2 == r_cap) begin
                    w_cnt_nx = r_cnt + 8'd1;
                    if (r_cnt == DEB_LAST) begin
                        w_accept   = 1'b1;
                        w_state_nx = HELD;
                    end
                end else begin
                    w_cnt_nx   = 8'd0;
                    w_state_nx = IDLE;
                end
            end
            HELD: begin
                if (w_sv_zero) begin
                    w_cnt_nx = 8'd1;
                    if (DEB_ONE) begin
                        w_bits_nx  = IDLE_CODE;
                        w_cnt_nx   = 8'd0;
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = DEB_REL;
                    end
                end
            end
            DEB_REL: begin
                if (w_sv_zero) begin
                    w_cnt_nx = r_cnt + 8'd1;
                    if (r_cnt == DEB_LAST) begin
                        w_bits_nx  = IDLE_CODE;
                        w_cnt_nx   = 8'd0;
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_state_nx = HELD;
                end
            end
            default: begin
                w_cnt_nx   = 8'd0;
                w_bits_nx  = IDLE_CODE;
                w_state_nx = IDLE;
            end
        endcase
        if (w_accept) w_bits_nx = w_idx_nx;
    end

    // A valid load replaces the stepping base, so a same-edge accept steps from it.
    always_comb begin
        w_load_ok = (r_state == IDLE) && kb.load &&
                    (kb.init_l <= LAST_POS) && (kb.init_m <= LAST_POS) &&
                    (kb.init_r <= LAST_POS);
        w_base_l   = w_load_ok ? kb.init_l : r_rot_l;
        w_base_m   = w_load_ok ? kb.init_m : r_rot_m;
        w_base_r   = w_load_ok ? kb.init_r : r_rot_r;
        w_carry_m  = w_accept && (w_base_r == NR);
        w_carry_l  = w_carry_m && (w_base_m == NM);
        w_rot_r_nx = w_accept  ? wrap_inc(w_base_r) : w_base_r;
        w_rot_m_nx = w_carry_m ? wrap_inc(w_base_m) : w_base_m;
        w_rot_l_nx = w_carry_l ? wrap_inc(w_base_l) : w_base_l;
    end

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            r_sync1  <= 26'd0;
            r_sync2  <= 26'd0;
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_cap    <= 26'd0;
            r_idx    <= 5'd0;
            r_bits   <= IDLE_CODE;
            r_strobe <= 1'b0;
            r_rot_l  <= 5'd0;
            r_rot_m  <= 5'd0;
            r_rot_r  <= 5'd0;
        end else begin
            r_sync1  <= kb.keys;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_cap    <= w_cap_nx;
            r_idx    <= w_idx_nx;
            r_bits   <= w_bits_nx;
            r_strobe <= w_accept;
            r_rot_l  <= w_rot_l_nx;
            r_rot_m  <= w_rot_m_nx;
            r_rot_r  <= w_rot_r_nx;
        end
    end

    assign kb.bits       = r_bits;
    assign kb.key_strobe = r_strobe;
    assign kb.rotor_l    = r_rot_l;
    assign kb.rotor_m    = r_rot_m;
    assign kb.rotor_r    = r_rot_r;
    assign kb.dbg_state  = r_state;

endmodule
